decode_issue: RTL and testbench
===============================

Name: decode_issue

Overview:
- RV32I(M) decode/issue stage; the producer end of the operand interface the execute stage consumes.
- Accepts fetched instructions on a valid/ready handshake and decodes the fields.
- Reads an internal 32x32 register file, which writeback updates, and assembles the immediate.
- Blocks read-after-write hazards with a pending-write scoreboard; presents one registered issue slot to execute.

Parameters:
- NUM_REGS, 32, architectural register count; only 32 is supported.
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch offers an instruction.
- if_ready  out  1  decode accepts this cycle.
- if_instr  in  32  instruction word.
- if_pc  in  32  word-indexed PC of if_instr.
- wb_en  in  1  register write from writeback.
- wb_rd  in  5  writeback destination.
- wb_data  in  32  writeback value.
- flush  in  1  kill the held issue slot (taken branch or jump).
- ex_valid  out  1  issue slot holds an instruction.
- ex_ready  in  1  execute takes the slot.
- ex_opcode  out  7  instr[6:0].
- ex_funct3  out  3  instr[14:12].
- ex_funct  out  7  instr[31:25].
- ex_shamt  out  5  instr[24:20].
- ex_rd  out  5  instr[11:7]; forced to 0 for formats that do not write rd.
- ex_rs1_value  out  32  rs1 operand.
- ex_rs2_value  out  32  rs2 operand.
- ex_pc_value  out  32  PC.
- ex_imm  out  32  decoded immediate.
- ex_illegal  out  1  unsupported encoding.

Behaviour:
- Reset (asynchronous): all ex_* outputs are 0. The scoreboard is cleared. Register file contents are 0.
- Register file: x0 reads 0 and ignores writes. A write on wb_en takes effect at the edge.
- Bypass: a same-cycle read of wb_rd (rd≠0) with wb_en high returns wb_data.
- Source use:
  - rs1 is used by opcodes 0110011, 0010011, 0000011, 0100011, 1100011 and 1100111.
  - rs2 is used by 0110011, 0100011 and 1100011.
- rd writers: 0110111, 0010111, 1101111, 1100111, 0000011, 0010011, 0110011.
- Immediate, sign-extended to 32 bits:
  - I-type: 0010011, 0000011, 1100111.
  - S-type: 0100011.
  - B-type: 1100011.
  - J-type: 1101111.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - Illegal encodings: 0.
- Scoreboard: one pending bit per register.
  - Set on the ex handshake (ex_valid && ex_ready) when ex_rd≠0.
  - Cleared when wb_en is high for that rd.
  - A set and a clear to the same register in the same cycle: the set wins.
- Hazard: the incoming instruction uses rs≠0 and either
  - rs is pending and not cleared by a same-cycle wb_en, or
  - rs equals the rd of the currently held valid slot.
- if_ready = (!ex_valid || ex_ready) && !hazard && !flush. This is combinational from if_instr.
- Latency: an instruction accepted in cycle N appears on the ex_* outputs in cycle N+1.
- The slot holds stable while ex_valid && !ex_ready.
- Back-to-back issue at one instruction per cycle is possible when there is no hazard.
- Flush: ex_valid goes to 0 at the next edge. The killed slot never sets the scoreboard. No fetch is accepted during the flush cycle. Pending bits already set remain set.
- Illegal:
  - Opcode outside the supported set: ex_illegal=1, ex_rd=0, no scoreboard effect; the slot is still issued.
  - Opcodes 0001111 and 1110011 are reported illegal.
- Reset mid-stall: the slot and the scoreboard are cleared immediately.

Optional Feature:
- Macro: DECODE_RV32M_EN.
- Defined: opcode 0110011 with funct7=0000001 is legal (mul/div/rem).
- Undefined: that encoding sets ex_illegal=1 and ex_rd=0.

Decomposition:
- Package rv32_pkg holds:
  - opcode localparams: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG;
  - funct7 constants F7_BASE, F7_ALT, F7_MULDIV;
  - an enum imm_fmt_e {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE}.
- One sub-module: imm_gen (combinational, instruction + format → 32-bit immediate).
- The register file and scoreboard stay inline.

Test Plan:
- Issue addi x1,x0,5 (0x00500093) at pc 4 → next cycle ex_valid=1, ex_imm=5, ex_rd=1, ex_rs1_value=0, ex_pc_value=4.
- Issue addi x1; then add x2,x1,x1 with ex_ready=1 and no writeback → if_ready=0 for the add. Then wb_en, wb_rd=1, wb_data=5 → the add is accepted the same cycle with ex_rs1_value=ex_rs2_value=5.
- Issue beq with a negative offset (0xFE000EE3) → ex_imm=0xFFFFFFFC, ex_rd=0, no scoreboard bit set.
- Issue lui x3,0x12345 (0x123451B7) → ex_imm=0x12345000.
- Hold ex_ready=0 for 3 cycles → the ex_* outputs stay stable and if_ready=0. Assert flush → ex_valid=0 next cycle and x-rd is not pending afterwards.
- Issue mul x4,x1,x2 (0x02208233) → ex_illegal=0 with DECODE_RV32M_EN defined, 1 without it. Assert rst_n=0 mid-stall → all ex_* outputs read 0 immediately.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I(M) decode constants, immediate formats and the issue-slot record.
package rv32_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        illegal;
  } issue_slot_t;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    imm_fmt_e fmt;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
      OP_STORE:                 fmt = FMT_S;
      OP_BRANCH:                fmt = FMT_B;
      OP_JAL:                   fmt = FMT_J;
      OP_LUI, OP_AUIPC:         fmt = FMT_U;
      default:                  fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate assembly for the RV32I instruction formats.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    unique case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_NONE: imm = '0;
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_issue.sv
// RV32I decode/issue stage: register file, pending-write scoreboard and one issue slot.
// Define DECODE_RV32M_EN to accept the M-extension (funct7=0000001) register ops as legal.
module decode_issue
  import rv32_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct,
  output logic [4:0]      ex_shamt,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_rs1_value,
  output logic [XLEN-1:0] ex_rs2_value,
  output logic [XLEN-1:0] ex_pc_value,
  output logic [XLEN-1:0] ex_imm,
  output logic            ex_illegal
);

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];

  // Decode
  logic legal, uses_rs1, uses_rs2, writes_rd;
  always_comb begin
    legal     = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        legal     = 1'b1;
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        legal    = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_REG: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
`ifdef DECODE_RV32M_EN
        legal     = 1'b1;
`else
        legal     = (if_instr[31:25] != F7_MULDIV);
`endif
        writes_rd = legal;
      end
      default: ;
    endcase
  end

  imm_fmt_e    fmt;
  logic [31:0] imm;
  assign fmt = legal ? imm_fmt(opcode) : FMT_NONE;

  imm_gen u_imm_gen (
    .instr (if_instr),
    .fmt   (fmt),
    .imm   (imm)
  );

  // Register file; entry 0 is never written so x0 stays zero.
  logic [XLEN-1:0] rf_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_rd != '0) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  logic [XLEN-1:0] rs1_val, rs2_val;
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != '0) rs1_val = (wb_en && wb_rd == rs1) ? wb_data : rf_q[rs1];
    if (rs2 != '0) rs2_val = (wb_en && wb_rd == rs2) ? wb_data : rf_q[rs2];
  end

  // Issue slot and scoreboard state
  logic        valid_q, valid_d;
  issue_slot_t slot_q, slot_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;

  logic hz1, hz2, hazard, accept, ex_fire;
  always_comb begin
    hz1 = uses_rs1 && rs1 != '0 &&
          ((pend_q[rs1] && !(wb_en && wb_rd == rs1)) || (valid_q && slot_q.rd == rs1));
    hz2 = uses_rs2 && rs2 != '0 &&
          ((pend_q[rs2] && !(wb_en && wb_rd == rs2)) || (valid_q && slot_q.rd == rs2));
  end

  assign hazard   = hz1 || hz2;
  assign if_ready = (!valid_q || ex_ready) && !hazard && !flush;
  assign accept   = if_valid && if_ready;
  // A flushed slot is dead even if execute asserts ready in the same cycle.
  assign ex_fire  = valid_q && ex_ready && !flush;

  always_comb begin
    pend_d = pend_q;
    if (wb_en) pend_d[wb_rd] = 1'b0;
    if (ex_fire && slot_q.rd != '0) pend_d[slot_q.rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    valid_d = valid_q;
    slot_d  = slot_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d          = 1'b1;
      slot_d.opcode    = opcode;
      slot_d.funct3    = if_instr[14:12];
      slot_d.funct7    = if_instr[31:25];
      slot_d.shamt     = if_instr[24:20];
      slot_d.rd        = writes_rd ? rd : 5'd0;
      slot_d.rs1_value = rs1_val;
      slot_d.rs2_value = rs2_val;
      slot_d.pc        = if_pc;
      slot_d.imm       = imm;
      slot_d.illegal   = !legal;
    end else if (ex_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
      pend_q  <= '0;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
      pend_q  <= pend_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_opcode    = slot_q.opcode;
  assign ex_funct3    = slot_q.funct3;
  assign ex_funct     = slot_q.funct7;
  assign ex_shamt     = slot_q.shamt;
  assign ex_rd        = slot_q.rd;
  assign ex_rs1_value = slot_q.rs1_value;
  assign ex_rs2_value = slot_q.rs2_value;
  assign ex_pc_value  = slot_q.pc;
  assign ex_imm       = slot_q.imm;
  assign ex_illegal   = slot_q.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: decode vector table, hazard/stall/flush/reset
// sequences and a randomized run against a behavioural model.
module tb_decode_issue;

`ifdef DECODE_RV32M_EN
  localparam bit MulLegal = 1'b1;
`else
  localparam bit MulLegal = 1'b0;
`endif

  logic        clk, rst_n;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, ex_valid, ex_ready;
  logic [6:0]  ex_opcode, ex_funct;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_shamt, ex_rd;
  logic [31:0] ex_rs1_value, ex_rs2_value, ex_pc_value, ex_imm;
  logic        ex_illegal;

  decode_issue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_opcode    (ex_opcode),
    .ex_funct3    (ex_funct3),
    .ex_funct     (ex_funct),
    .ex_shamt     (ex_shamt),
    .ex_rd        (ex_rd),
    .ex_rs1_value (ex_rs1_value),
    .ex_rs2_value (ex_rs2_value),
    .ex_pc_value  (ex_pc_value),
    .ex_imm       (ex_imm),
    .ex_illegal   (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit rdy, input bit we, input logic [4:0] wr,
                       input logic [31:0] wd, input bit fl);
    @(negedge clk);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
    ex_ready = rdy;
    wb_en    = we;
    wb_rd    = wr;
    wb_data  = wd;
    flush    = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    if_valid = 1'b0;
    if_instr = 32'h0000_0013;
    if_pc    = '0;
    ex_ready = 1'b0;
    wb_en    = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    flush    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_rf [32];
  bit          m_pend [32];
  bit          m_valid;
  logic [31:0] m_instr, m_pc, m_r1, m_r2, m_imm;
  logic [4:0]  m_rd;
  bit          m_ill;

  function automatic bit m_legal(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op == 7'h33 && ins[31:25] == 7'h01) return MulLegal;
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction

  function automatic bit m_uses1(input logic [31:0] ins);
    return ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction

  function automatic bit m_uses2(input logic [31:0] ins);
    return ins[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic bit m_writes(input logic [31:0] ins);
    return m_legal(ins) && (ins[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33});
  endfunction

  // Immediate by field weighting and explicit two's-complement wrap.
  function automatic logic [31:0] m_immf(input logic [31:0] ins);
    int v;
    v = 0;
    if (!m_legal(ins)) return 32'd0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: begin
        v = int'(ins[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 +
            int'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h6F: begin
        v = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 +
            int'(ins[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      7'h37, 7'h17: return ins & 32'hFFFF_F000;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic bit m_blocked(input logic [4:0] r);
    return r != 0 && ((m_pend[r] && !(wb_en && wb_rd == r)) || (m_valid && m_rd == r));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_en && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  task automatic model_cycle();
    bit hz, rdy, acc;
    logic [31:0] v1, v2;
    hz  = (m_uses1(if_instr) && m_blocked(if_instr[19:15])) ||
          (m_uses2(if_instr) && m_blocked(if_instr[24:20]));
    rdy = (!m_valid || ex_ready) && !hz && !flush;
    chk("rand_if_ready", if_ready, rdy);
    acc = if_valid && rdy;
    v1  = m_read(if_instr[19:15]);
    v2  = m_read(if_instr[24:20]);
    if (wb_en) m_pend[wb_rd] = 1'b0;
    if (m_valid && ex_ready && !flush && m_rd != 0) m_pend[m_rd] = 1'b1;
    if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      m_instr = if_instr;
      m_pc    = if_pc;
      m_r1    = v1;
      m_r2    = v2;
      m_imm   = m_immf(if_instr);
      m_rd    = m_writes(if_instr) ? if_instr[11:7] : 5'd0;
      m_ill   = !m_legal(if_instr);
    end else if (ex_ready) m_valid = 1'b0;
  endtask

  task automatic check_slot();
    chk("rand_ex_valid", ex_valid, m_valid);
    if (m_valid) begin
      chk("rand_ex_rd", ex_rd, m_rd);
      chk("rand_ex_imm", ex_imm, m_imm);
      chk("rand_ex_rs1", ex_rs1_value, m_r1);
      chk("rand_ex_rs2", ex_rs2_value, m_r2);
      chk("rand_ex_pc", ex_pc_value, m_pc);
      chk("rand_ex_illegal", ex_illegal, m_ill);
      chk("rand_ex_fields", {ex_funct, ex_shamt, ex_funct3, ex_opcode},
          {m_instr[31:25], m_instr[24:20], m_instr[14:12], m_instr[6:0]});
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  op;
    case ($urandom_range(0, 10))
      0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
      4: op = 7'h63;  5: op = 7'h03;  6: op = 7'h23;  7: op = 7'h13;
      8: op = 7'h33;  9: op = 7'h0F;  default: op = 7'h33;
    endcase
    ins        = $urandom;
    ins[6:0]   = op;
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    if (op == 7'h33) begin
      case ($urandom_range(0, 2))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        default: ins[31:25] = 7'h01;
      endcase
    end
    return ins;
  endfunction

  // ---------------- decode vector table ----------------
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    bit          ill;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"addi_x1_5",  32'h0050_0093, 32'd4,  32'd5,         5'd1, 1'b0};
    vecs[1] = '{"beq_neg4",   32'hFE00_0EE3, 32'd8,  32'hFFFF_FFFC, 5'd0, 1'b0};
    vecs[2] = '{"lui_x3",     32'h1234_51B7, 32'd12, 32'h1234_5000, 5'd3, 1'b0};
    vecs[3] = '{"mul_x4",     32'h0220_8233, 32'd16, 32'd0,
                (MulLegal ? 5'd4 : 5'd0), !MulLegal};
    vecs[4] = '{"fence",      32'h0000_000F, 32'd20, 32'd0,         5'd0, 1'b1};
    vecs[5] = '{"ecall",      32'h0000_0073, 32'd24, 32'd0,         5'd0, 1'b1};
    vecs[6] = '{"sw_8",       32'h0020_2423, 32'd28, 32'd8,         5'd0, 1'b0};
    vecs[7] = '{"jal_neg8",   32'hFF9F_F0EF, 32'd32, 32'hFFFF_FFF8, 5'd1, 1'b0};
    vecs[8] = '{"lw_neg1",    32'hFFF0_2283, 32'd36, 32'hFFFF_FFFF, 5'd5, 1'b0};
    vecs[9] = '{"auipc_x6",   32'h0000_1317, 32'd40, 32'h0000_1000, 5'd6, 1'b0};

    do_reset();
    #1;
    chk("reset_ex_valid", ex_valid, 1'b0);
    chk("reset_ex_zero", 32'(|{ex_opcode, ex_funct3, ex_funct, ex_shamt, ex_rd, ex_rs1_value,
                               ex_rs2_value, ex_pc_value, ex_imm, ex_illegal}), 32'd0);
    drive(1'b0, 32'h0000_0013, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("reset_if_ready", if_ready, 1'b1);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      drive(1'b1, vecs[i].instr, vecs[i].pc, 1'b1, 1'b0, 0, 0, 1'b0);
      chk({vecs[i].name, "_if_ready"}, if_ready, 1'b1);
      tick();
      chk({vecs[i].name, "_valid"}, ex_valid, 1'b1);
      chk({vecs[i].name, "_imm"}, ex_imm, vecs[i].imm);
      chk({vecs[i].name, "_rd"}, ex_rd, vecs[i].rd);
      chk({vecs[i].name, "_illegal"}, ex_illegal, vecs[i].ill);
      chk({vecs[i].name, "_pc"}, ex_pc_value, vecs[i].pc);
      chk({vecs[i].name, "_rs1"}, ex_rs1_value, 32'd0);
    end

    // Read-after-write: blocked by the held slot, then by the pending bit, released by wb.
    do_reset();
    drive(1'b1, 32'h0050_0093, 4, 1'b1, 1'b0, 0, 0, 1'b0);
    tick();
    drive(1'b1, 32'h0010_8133, 8, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("raw_slot_block", if_ready, 1'b0);
    tick();
    drive(1'b1, 32'h0010_8133, 8, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("raw_slot_drained", ex_valid, 1'b0);
    chk("raw_pend_block", if_ready, 1'b0);
    tick();
    drive(1'b1, 32'h0010_8133, 8, 1'b1, 1'b1, 5'd1, 32'd5, 1'b0);
    chk("raw_wb_release", if_ready, 1'b1);
    tick();
    chk("raw_add_rd", ex_rd, 5'd2);
    chk("raw_add_rs1", ex_rs1_value, 32'd5);
    chk("raw_add_rs2", ex_rs2_value, 32'd5);

    // Stall for three cycles, then flush with ex_ready high.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h1234_51B7, 12, 1'b0, 1'b0, 0, 0, 1'b0);
      chk("stall_if_ready", if_ready, 1'b0);
      tick();
      chk("stall_hold", {ex_valid, ex_rd, ex_pc_value[7:0], ex_rs1_value[7:0], ex_rs2_value[7:0]},
          {1'b1, 5'd2, 8'd8, 8'd5, 8'd5});
    end
    drive(1'b1, 32'h1234_51B7, 12, 1'b1, 1'b0, 0, 0, 1'b1);
    chk("flush_if_ready", if_ready, 1'b0);
    tick();
    chk("flush_ex_valid", ex_valid, 1'b0);
    drive(1'b1, 32'h0001_0393, 16, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("flush_no_pending", if_ready, 1'b1);
    tick();
    chk("post_flush_rd", ex_rd, 5'd7);

    // M-extension legality, then asynchronous reset while stalled.
    drive(1'b1, 32'h0220_8233, 20, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("mul_if_ready", if_ready, 1'b1);
    tick();
    chk("mul_illegal", ex_illegal, !MulLegal);
    chk("mul_rd", ex_rd, MulLegal ? 5'd4 : 5'd0);
    drive(1'b1, 32'h0050_0093, 24, 1'b0, 1'b0, 0, 0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midstall_reset_valid", ex_valid, 1'b0);
    chk("midstall_reset_zero", 32'(|{ex_opcode, ex_funct3, ex_funct, ex_shamt, ex_rd,
                                     ex_rs1_value, ex_rs2_value, ex_pc_value, ex_imm,
                                     ex_illegal}), 32'd0);

    // Randomized run against the model.
    do_reset();
    for (int r = 0; r < 32; r++) begin
      m_rf[r]   = '0;
      m_pend[r] = 1'b0;
    end
    m_valid = 1'b0;
    m_rd    = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if_valid = ($urandom_range(0, 4) != 0);
      if_instr = rand_instr();
      if_pc    = $urandom;
      ex_ready = ($urandom_range(0, 3) != 0);
      wb_en    = ($urandom_range(0, 2) == 0);
      wb_rd    = 5'($urandom_range(0, 3));
      wb_data  = $urandom;
      flush    = ($urandom_range(0, 15) == 0);
      #1;
      model_cycle();
      tick();
      check_slot();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
